dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate cache controller that sequences the 8-set x 256-bit byte-enabled data array.
- Accepts 32-bit CPU requests.
- Owns tag, valid and dirty state internally.
- Performs line writeback and fill over a 256-bit physical-memory port.
- Drives the data array's write_en, rindex, windex and datain; consumes its dataout.

---
 rtl/dcache_ctrl.sv | 87 ++++++++
 tb/tb_dcache_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate cache controller driving an 8x256-bit data array
module dcache_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  da_write_en,
  output logic [2:0]   da_rindex,
  output logic [2:0]   da_windex,
  output logic [255:0] da_datain,
  input  logic [255:0] da_dataout
);
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;
  state_t      r_state;
  logic [23:0] r_tag [8];
  logic [7:0]  r_valid, r_dirty;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_write;
  logic [2:0]  w_idx, w_word;
  logic [23:0] w_tag;
  logic        w_hit, w_cmp, w_fill_done;
  assign w_idx  = r_addr[7:5];
  assign w_word = r_addr[4:2];
  assign w_tag  = r_addr[31:8];
  assign w_hit  = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  // reset gates the array write and response so a miss aborted by reset leaves no trace
  assign w_cmp       = r_state == COMPARE && !rst;
  assign w_fill_done = r_state == FILL && pmem_resp && !rst;
  assign mem_resp     = w_cmp && w_hit;
  assign mem_rdata    = (mem_resp && !r_write) ? da_dataout[{w_word, 5'b0} +: 32] : '0;
  assign pmem_write   = r_state == WRITEBACK;
  assign pmem_read    = r_state == FILL;
  assign pmem_address = pmem_write ? {r_tag[w_idx], w_idx, 5'b0} : pmem_read ? {w_tag, w_idx, 5'b0} : '0;
  assign pmem_wdata   = pmem_write ? da_dataout : '0;
  assign da_write_en  = w_fill_done ? '1 : (mem_resp && r_write) ? 32'(r_be) << {w_word, 2'b00} : '0;
  assign da_datain    = pmem_read ? pmem_rdata : {8{r_wdata}};
  assign da_rindex    = r_state == IDLE ? mem_address[7:5] : w_idx;
  assign da_windex    = da_rindex;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_write <= 1'b0;
      for (int i = 0; i < 8; i++) r_tag[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (mem_read || mem_write) begin
          r_addr  <= mem_address;
          r_wdata <= mem_wdata;
          r_be    <= mem_byte_enable;
          r_write <= mem_write;
          r_state <= COMPARE;
        end
        COMPARE: if (w_hit) begin
          if (r_write) r_dirty[w_idx] <= 1'b1;
          r_state <= IDLE;
        end else r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : FILL;
        WRITEBACK: if (pmem_resp) begin
          r_dirty[w_idx] <= 1'b0;
          r_state <= FILL;
        end
        FILL: if (pmem_resp) begin
          r_tag[w_idx]   <= w_tag;
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
          r_state <= COMPARE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with a reference cache model, data array model and pmem responder
module tb_dcache_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic mem_read = 0, mem_write = 0, mem_resp, pmem_read, pmem_write, pmem_resp = 0;
  logic [31:0] mem_address = 0, mem_wdata = 0, mem_rdata, pmem_address, da_write_en;
  logic [3:0] mem_byte_enable = 0;
  logic [255:0] pmem_wdata, pmem_rdata = 0, da_datain, da_dataout;
  logic [2:0] da_rindex, da_windex;
  dcache_ctrl dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .da_write_en(da_write_en), .da_rindex(da_rindex),
    .da_windex(da_windex), .da_datain(da_datain), .da_dataout(da_dataout)
  );
  logic [255:0] arr [8];
  assign da_dataout = arr[da_rindex];
  always @(posedge clk)
    for (int b = 0; b < 32; b++) if (da_write_en[b]) arr[da_windex][8*b +: 8] <= da_datain[8*b +: 8];
  int total = 0, bad = 0, cyc = 0, lat = 2, cnt = 0, last_pr = -10, viol = 0, ovl = 0;
  logic [31:0] last_rd, pa;
  always @(posedge clk) cyc++;
  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  logic [255:0] pmem [int];
  logic [255:0] bmem [int];
  function automatic logic [255:0] dflt(int k);
    return {8{32'hC0DE0000 | 32'(k)}};
  endfunction
  function automatic logic [255:0] rd_p(int k);
    return pmem.exists(k) ? pmem[k] : dflt(k);
  endfunction
  function automatic logic [255:0] rd_b(int k);
    return bmem.exists(k) ? bmem[k] : dflt(k);
  endfunction
  logic [23:0] mtag [8];
  bit mval [8], mdir [8];
  logic [255:0] mline [8];
  typedef struct {bit w; logic [31:0] a; logic [255:0] d;} ptx_t;
  typedef struct {bit rd; bit miss; logic [31:0] d;} rtx_t;
  ptx_t pq[$], pe;
  rtx_t rq[$], re;
  task automatic req(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    int i = int'(a[7:5]);
    int wd = int'(a[4:2]);
    bit hit = mval[i] && mtag[i] == a[31:8];
    int n = 0;
    int k;
    if (!hit) begin
      if (mval[i] && mdir[i]) begin
        k = int'({mtag[i], a[7:5]});
        pq.push_back('{1'b1, {mtag[i], a[7:5], 5'b0}, mline[i]});
        bmem[k] = mline[i];
      end
      k = int'(a[31:5]);
      pq.push_back('{1'b0, {a[31:5], 5'b0}, '0});
      mline[i] = rd_b(k);
      mtag[i] = a[31:8];
      mval[i] = 1;
      mdir[i] = 0;
    end
    if (w) begin
      for (int b = 0; b < 4; b++) if (be[b]) mline[i][32*wd + 8*b +: 8] = d[8*b +: 8];
      mdir[i] = 1;
    end
    rq.push_back('{!w, !hit, mline[i][32*wd +: 32]});
    @(negedge clk);
    mem_address = a; mem_wdata = d; mem_byte_enable = be; mem_read = !w; mem_write = w;
    do begin @(negedge clk); n++; end while (!mem_resp && n < 500);
    last_rd = mem_rdata;
    mem_read = 0; mem_write = 0;
    if (!mem_resp) chk("resp_timeout", 0, 1);
    if (hit) chk("hit_lat", n, 1);
  endtask
  always @(negedge clk)
    if (mem_resp) begin
      if (rq.size() == 0) chk("resp_unexp", 1, 0);
      else begin
        re = rq.pop_front();
        if (re.rd) chk("rdata", mem_rdata, re.d);
        if (re.miss) chk("miss_lat", cyc - last_pr, 1);
      end
    end
  always @(negedge clk) begin
    pmem_resp = 0;
    if (pmem_read && pmem_write) ovl++;
    if (pmem_read || pmem_write) begin
      if (cnt > 0 && (pmem_address !== pa || mem_resp)) viol++;
      pa = pmem_address;
      if (cnt >= lat) begin
        cnt = 0;
        pmem_resp = 1;
        last_pr = cyc;
        if (pmem_write) pmem[int'(pmem_address[31:5])] = pmem_wdata;
        else pmem_rdata = rd_p(int'(pmem_address[31:5]));
        if (pq.size() == 0) chk("pmem_unexp", 1, 0);
        else begin
          pe = pq.pop_front();
          chk("pmem_op", pmem_write, pe.w);
          chk("pmem_addr", pmem_address, pe.a);
          if (pmem_write) chk("pmem_wdata", pmem_wdata, pe.d);
        end
      end else cnt++;
    end else cnt = 0;
  end
  initial begin
    logic [255:0] ln;
    int n;
    for (int i = 0; i < 8; i++) begin arr[i] = '0; mval[i] = 0; mdir[i] = 0; mtag[i] = 0; mline[i] = 0; end
    ln = '0; ln[63:32] = 32'hDEADBEEF;
    pmem[1] = ln; bmem[1] = ln;
    ln = dflt(2); ln[63:32] = 32'hAAAAAAAA;
    pmem[2] = ln; bmem[2] = ln;
    repeat (3) @(negedge clk);
    chk("rst_resp", mem_resp, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    chk("rst_we", da_write_en, 0);
    chk("rst_paddr", pmem_address, 0);
    rst = 0;
    req(0, 32'h20, 0, 0);           chk("plan_rd20", last_rd, 32'h0);
    req(0, 32'h24, 0, 0);           chk("plan_rd24", last_rd, 32'hDEADBEEF);
    req(0, 32'h40, 0, 0);
    req(1, 32'h44, 32'h11223344, 4'b0011);
    req(0, 32'h44, 0, 0);           chk("plan_rd44", last_rd, 32'hAAAA3344);
    req(0, 32'h10040, 0, 0);
    req(0, 32'h44, 0, 0);           chk("plan_wb44", last_rd, 32'hAAAA3344);
    req(0, 32'h100, 0, 0);
    req(0, 32'h200, 0, 0);
    req(1, 32'h204, 32'hFFFFFFFF, 4'b0000);
    req(0, 32'h100, 0, 0);
    req(0, 32'h204, 0, 0);          chk("plan_be0", last_rd, dflt(16)[63:32]);
    for (int t = 0; t < 40; t++)
      req($urandom_range(0, 1) == 1, {22'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom), 2'b0},
          $urandom, 4'($urandom));
    lat = 50;
    req(0, 32'h5C0, 0, 0);
    lat = 1000;
    @(negedge clk);
    mem_address = 32'h3E0; mem_read = 1;
    n = 0;
    while (!pmem_read && n < 20) begin @(negedge clk); n++; end
    chk("rst_fill_start", pmem_read, 1);
    repeat (3) @(negedge clk);
    rst = 1; mem_read = 0;
    @(negedge clk);
    chk("midrst_pread", pmem_read, 0);
    chk("midrst_resp", mem_resp, 0);
    chk("midrst_we", da_write_en, 0);
    rst = 0; lat = 2;
    for (int i = 0; i < 8; i++) begin mval[i] = 0; mdir[i] = 0; end
    req(0, 32'h3E0, 0, 0);
    repeat (3) @(negedge clk);
    chk("stall_viol", viol, 0);
    chk("overlap", ovl, 0);
    chk("pq_left", pq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
